// File: rtl/cpu_defs.sv
// Shared decode constants and types for the EX-stage multiply/divide unit.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  typedef enum logic [1:0] {
    MUL_S = 2'd0,
    MUL_U = 2'd1,
    DIV_S = 2'd2,
    DIV_U = 2'd3
  } muldiv_kind_t;

  // True for the two divide kinds.
  function automatic logic kind_is_div(input muldiv_kind_t kind);
    return (kind == DIV_S) || (kind == DIV_U);
  endfunction

  // True for the two signed kinds.
  function automatic logic kind_is_signed(input muldiv_kind_t kind);
    return (kind == MUL_S) || (kind == DIV_S);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned multiply/divide datapath.
//   kind_i  : op kind; divide kinds use restoring shift-subtract,
//             multiply kinds use shift-add
//   hi_i/o  : accumulator high word (product high / partial remainder)
//   lo_i/o  : accumulator low word (multiplier+product low / dividend+quotient)
//   opnd_i  : multiplicand magnitude or divisor magnitude
module muldiv_step
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  muldiv_kind_t     kind_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] mul_sum_c;
  logic [WIDTH:0] div_shift_c;
  logic           div_ge_c;

  always_comb begin
    // Multiply: conditionally add, then shift the whole {carry,hi,lo} right.
    mul_sum_c   = {1'b0, hi_i} + {1'b0, (lo_i[0] ? opnd_i : {WIDTH{1'b0}})};
    // Divide: the partial remainder needs one extra bit after the left shift.
    div_shift_c = {hi_i, lo_i[WIDTH-1]};
    div_ge_c    = (div_shift_c >= {1'b0, opnd_i});

    if (kind_is_div(kind_i)) begin
      // A kept remainder is below the divisor, so it always fits WIDTH bits.
      hi_o = div_ge_c ? WIDTH'(div_shift_c - {1'b0, opnd_i}) : div_shift_c[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], div_ge_c};
    end else begin
      hi_o = mul_sum_c[WIDTH:1];
      lo_o = {mul_sum_c[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage; state updates on the
// falling clock edge like the surrounding pipeline registers.
//   op_ex, func_ex, busA_ex, busB_ex, xiaoc_ex : instruction in EX
//   stall   : hold PC, IF/ID and ID/EX (combinational)
//   busy    : unit not idle
//   hilo_we : one-cycle Hi/Lo write strobe
//   hi_res  : product high word or remainder (held until the next write)
//   lo_res  : product low word or quotient (held until the next write)
// CNT_W must satisfy 2**CNT_W == WIDTH.
module ex_muldiv_unit
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_ex,
  input  logic [5:0]       func_ex,
  input  logic [WIDTH-1:0] busA_ex,
  input  logic [WIDTH-1:0] busB_ex,
  input  logic             xiaoc_ex,
  output logic             stall,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int unsigned PROD_W = 2 * WIDTH;

  muldiv_state_t    state_q, state_d;
  muldiv_kind_t     kind_q, kind_d, req_kind_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dvz_q, dvz_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_res_q, hi_res_d;
  logic [WIDTH-1:0] lo_res_q, lo_res_d;

  logic             md_func_c, req_c, sign_a_c, sign_b_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH-1:0] step_hi_c, step_lo_c;
  logic [PROD_W-1:0] prod_c;
  logic [WIDTH-1:0] quo_c, rem_c;

  // Request decode and operand magnitudes for a new op.
  always_comb begin
    md_func_c  = 1'b1;
    req_kind_c = MUL_S;
    case (func_ex)
      FUNC_MULT:  req_kind_c = MUL_S;
      FUNC_MULTU: req_kind_c = MUL_U;
      FUNC_DIV:   req_kind_c = DIV_S;
      FUNC_DIVU:  req_kind_c = DIV_U;
      default:    md_func_c  = 1'b0;
    endcase
    req_c    = (op_ex == OP_RTYPE) && md_func_c && !xiaoc_ex;
    sign_a_c = kind_is_signed(req_kind_c) && busA_ex[WIDTH-1];
    sign_b_c = kind_is_signed(req_kind_c) && busB_ex[WIDTH-1];
    mag_a_c  = sign_a_c ? -busA_ex : busA_ex;
    mag_b_c  = sign_b_c ? -busB_ex : busB_ex;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .kind_i (kind_q),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi_c),
    .lo_o   (step_lo_c)
  );

  // Sign fixup on the final iteration's output. Divide-by-zero leaves the
  // quotient all ones; the remainder fixup then restores busA exactly.
  always_comb begin
    prod_c = {step_hi_c, step_lo_c};
    quo_c  = step_lo_c;
    rem_c  = step_hi_c;
    if ((kind_q == MUL_S) && (sign_a_q ^ sign_b_q)) begin
      prod_c = -prod_c;
    end
    if (kind_q == DIV_S) begin
      if ((sign_a_q ^ sign_b_q) && !dvz_q) begin
        quo_c = -quo_c;
      end
      if (sign_a_q) begin
        rem_c = -rem_c;
      end
    end
  end

  // Next-state and outputs.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dvz_d    = dvz_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_res_d = hi_res_q;
    lo_res_d = lo_res_q;
    stall    = 1'b0;
    busy     = 1'b0;
    hilo_we  = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by rst_n so a held request cannot stall while in reset.
        stall = req_c && rst_n;
        if (req_c) begin
          state_d  = RUN;
          kind_d   = req_kind_c;
          cnt_d    = '0;
          sign_a_d = sign_a_c;
          sign_b_d = sign_b_c;
          dvz_d    = (busB_ex == '0);
          hi_d     = '0;
          if (kind_is_div(req_kind_c)) begin
            lo_d   = mag_a_c;
            opnd_d = mag_b_c;
          end else begin
            lo_d   = mag_b_c;
            opnd_d = mag_a_c;
          end
        end
      end
      RUN: begin
        stall = 1'b1;
        busy  = 1'b1;
        hi_d  = step_hi_c;
        lo_d  = step_lo_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          if (kind_is_div(kind_q)) begin
            hi_res_d = rem_c;
            lo_res_d = quo_c;
          end else begin
            hi_res_d = prod_c[PROD_W-1:WIDTH];
            lo_res_d = prod_c[WIDTH-1:0];
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        hilo_we = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kind_q   <= MUL_S;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dvz_q    <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_res_q <= '0;
      lo_res_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dvz_q    <= dvz_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_res_q <= hi_res_d;
      lo_res_q <= lo_res_d;
    end
  end

  assign hi_res = hi_res_q;
  assign lo_res = lo_res_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed table, corner sequences,
// and random ops against an arithmetic reference model. The bench emulates
// the ID/EX register: an instruction stays on the inputs until a cycle in
// which stall is low.
module tb_ex_muldiv_unit;
  import cpu_defs::*;

  localparam int EX_OCC  = 34;          // cycles an op occupies EX (33 stall + DONE)
  localparam int LAT_WE  = EX_OCC - 1;  // cycle index of hilo_we, issue cycle = 0
  localparam int NSTALL  = 33;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op_ex, func_ex;
  logic [31:0] busA_ex, busB_ex;
  logic        xiaoc_ex;
  logic        stall, busy, hilo_we;
  logic [31:0] hi_res, lo_res;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_ex    (op_ex),
    .func_ex  (func_ex),
    .busA_ex  (busA_ex),
    .busB_ex  (busB_ex),
    .xiaoc_ex (xiaoc_ex),
    .stall    (stall),
    .busy     (busy),
    .hilo_we  (hilo_we),
    .hi_res   (hi_res),
    .lo_res   (lo_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic        x;
  } instr_t;

  typedef struct {
    string       name;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_t      prog[$];
  int          we_cyc[$];
  logic [31:0] we_hi[$];
  logic [31:0] we_lo[$];
  int          stall_cnt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] func,
                                input logic [31:0] a, input logic [31:0] b, input logic x);
    instr_t i;
    i.op = op; i.func = func; i.a = a; i.b = b; i.x = x;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    op_ex = i.op; func_ex = i.func; busA_ex = i.a; busB_ex = i.b; xiaoc_ex = i.x;
  endtask

  // Reference: {hi, lo} straight from the architectural definition.
  function automatic logic [63:0] ref_md(input logic [5:0] func, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb, q, r;
    sa = a;
    sb = b;
    case (func)
      FUNC_MULT: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      FUNC_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        return up;
      end
      FUNC_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Present prog[] through an emulated ID/EX register for ncyc cycles and
  // record every Hi/Lo strobe and the number of stalled cycles.
  task automatic run_prog(input int ncyc);
    int idx;
    idx = 0;
    we_cyc.delete(); we_hi.delete(); we_lo.delete();
    stall_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      if (idx < prog.size()) drive(prog[idx]);
      else drive(mk(6'h0, 6'h0, 32'h0, 32'h0, 1'b0));
      #1;
      if (stall) stall_cnt++;
      if (hilo_we) begin
        we_cyc.push_back(c);
        we_hi.push_back(hi_res);
        we_lo.push_back(lo_res);
      end
      if (!stall && idx < prog.size()) idx++;
    end
  endtask

  task automatic check_single(input string nm, input logic [31:0] eh, input logic [31:0] el);
    check({nm, ".stall_cycles"}, 64'(stall_cnt), 64'(NSTALL));
    check({nm, ".we_count"}, 64'(we_cyc.size()), 64'(1));
    if (we_cyc.size() > 0) begin
      check({nm, ".we_cycle"}, 64'(we_cyc[0]), 64'(LAT_WE));
      check({nm, ".hi"}, 64'(we_hi[0]), 64'(eh));
      check({nm, ".lo"}, 64'(we_lo[0]), 64'(el));
    end
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  fsel[4];
    logic [63:0] exp;
    logic [5:0]  rf;
    logic [31:0] ra, rb;

    fsel[0] = FUNC_MULT; fsel[1] = FUNC_MULTU; fsel[2] = FUNC_DIV; fsel[3] = FUNC_DIVU;

    vecs.push_back('{"mult_7_m3",     FUNC_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"multu_max",     FUNC_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_min_min",  FUNC_MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{"div_m7_2",      FUNC_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_100_7",    FUNC_DIVU,  32'd100,        32'd7,         32'd2,         32'd14});
    vecs.push_back('{"divu_5_0",      FUNC_DIVU,  32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{"div_m5_0",      FUNC_DIV,   32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf",       FUNC_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"div_7_m2",      FUNC_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});

    // Reset state.
    drive(mk(6'h0, 6'h0, 32'h0, 32'h0, 1'b0));
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.stall",   64'(stall),   64'(0));
    check("reset.busy",    64'(busy),    64'(0));
    check("reset.hilo_we", 64'(hilo_we), 64'(0));
    check("reset.hi",      64'(hi_res),  64'(0));
    check("reset.lo",      64'(lo_res),  64'(0));
    @(posedge clk);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[k]) begin
      prog.delete();
      prog.push_back(mk(OP_RTYPE, vecs[k].func, vecs[k].a, vecs[k].b, 1'b0));
      run_prog(40);
      check_single(vecs[k].name, vecs[k].hi, vecs[k].lo);
    end

    // Ops that must never stall or write Hi/Lo.
    prog.delete();
    prog.push_back(mk(OP_RTYPE, FUNC_MULT, 32'd3, 32'd4, 1'b1));
    run_prog(40);
    check("cancelled.stall_cycles", 64'(stall_cnt), 64'(0));
    check("cancelled.we_count", 64'(we_cyc.size()), 64'(0));

    prog.delete();
    prog.push_back(mk(OP_RTYPE, 6'b100000, 32'd3, 32'd4, 1'b0));
    run_prog(40);
    check("add.stall_cycles", 64'(stall_cnt), 64'(0));
    check("add.we_count", 64'(we_cyc.size()), 64'(0));

    prog.delete();
    prog.push_back(mk(6'b100011, FUNC_MULT, 32'd3, 32'd4, 1'b0));
    run_prog(40);
    check("non_rtype.stall_cycles", 64'(stall_cnt), 64'(0));
    check("non_rtype.we_count", 64'(we_cyc.size()), 64'(0));

    // Reset during RUN iteration 10 with the request still on the inputs.
    @(posedge clk);
    drive(mk(OP_RTYPE, FUNC_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
    repeat (11) @(posedge clk);
    #1;
    check("midrun.busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrun.stall",   64'(stall),   64'(0));
    check("midrun.busy",    64'(busy),    64'(0));
    check("midrun.hilo_we", 64'(hilo_we), 64'(0));
    check("midrun.hi",      64'(hi_res),  64'(0));
    check("midrun.lo",      64'(lo_res),  64'(0));
    drive(mk(6'h0, 6'h0, 32'h0, 32'h0, 1'b0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrun.hold_we[%0d]", c), 64'(hilo_we), 64'(0));
    end
    @(posedge clk);
    rst_n = 1'b1;
    prog.delete();
    prog.push_back(mk(OP_RTYPE, FUNC_DIVU, 32'd9, 32'd3, 1'b0));
    run_prog(40);
    check_single("after_reset_divu_9_3", 32'd0, 32'd3);
    check("after_reset.extra_we", 64'(we_cyc.size()), 64'(1));

    // Back-to-back MULT then DIV: the DIV enters EX when the MULT leaves.
    prog.delete();
    prog.push_back(mk(OP_RTYPE, FUNC_MULT, 32'hFFFF_FF00, 32'd12345, 1'b0));
    prog.push_back(mk(OP_RTYPE, FUNC_DIV,  32'hFFFF_0001, 32'd77,    1'b0));
    run_prog(2 * EX_OCC + 6);
    check("b2b.we_count", 64'(we_cyc.size()), 64'(2));
    check("b2b.stall_cycles", 64'(stall_cnt), 64'(2 * NSTALL));
    if (we_cyc.size() == 2) begin
      check("b2b.gap", 64'(we_cyc[1] - we_cyc[0]), 64'(EX_OCC));
      exp = ref_md(FUNC_MULT, 32'hFFFF_FF00, 32'd12345);
      check("b2b.mult_hi", 64'(we_hi[0]), 64'(exp[63:32]));
      check("b2b.mult_lo", 64'(we_lo[0]), 64'(exp[31:0]));
      exp = ref_md(FUNC_DIV, 32'hFFFF_0001, 32'd77);
      check("b2b.div_hi", 64'(we_hi[1]), 64'(exp[63:32]));
      check("b2b.div_lo", 64'(we_lo[1]), 64'(exp[31:0]));
    end

    // Random ops against the reference model.
    for (int n = 0; n < 24; n++) begin
      rf = fsel[$urandom_range(0, 3)];
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      exp = ref_md(rf, ra, rb);
      prog.delete();
      prog.push_back(mk(OP_RTYPE, rf, ra, rb, 1'b0));
      run_prog(40);
      check_single($sformatf("rand%0d_f%02h_%h_%h", n, rf, ra, rb), exp[63:32], exp[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
